// File: rtl/multicycle_controller.sv
// multicycle_controller
// Moore control FSM for a multi-cycle RV32I datapath. One ALU and one memory
// port are shared across fetch, decode, execute, memory and writeback steps;
// this block sequences those steps and drives the datapath mux selects, the
// write strobes and the ALU operation every cycle.
module multicycle_controller #(
    parameter int ALUCTRL_W = 4,   // 3 = base op set, 4 adds shifts, XOR, SLTU
    parameter int WAIT_MEM  = 1    // 1 = memory states hold until mem_ready
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic                 ir_write,
    output logic                 reg_write,
    output logic                 mem_write,
    output logic                 adr_src,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           result_src,
    output logic [2:0]           imm_src,
    output logic [ALUCTRL_W-1:0] alu_control,
    output logic                 illegal,
    output logic [3:0]           state
);

    // ------------------------------------------------------------------
    // Encodings
    // ------------------------------------------------------------------
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LUI      = 4'd12,
        S_TRAP     = 4'd15
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLL  = 4'd6,
        ALU_SRL  = 4'd7,
        ALU_SRA  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RD1   = 2'b10;

    localparam logic [1:0] SRC_B_RD2   = 2'b00;
    localparam logic [1:0] SRC_B_IMM   = 2'b01;
    localparam logic [1:0] SRC_B_FOUR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_DATA    = 2'b01;
    localparam logic [1:0] RES_ALURES  = 2'b10;
    localparam logic [1:0] RES_IMMEXT  = 2'b11;

    // Narrow ALU control cannot encode shifts, XOR or SLTU.
    localparam bit NARROW_ALU = (ALUCTRL_W < 4);

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    state_t  state_q;
    state_t  state_d;
    alu_op_t alu_code;
    alu_op_t funct_op;
    logic    funct_unsupported;
    logic    mem_done;

    // With WAIT_MEM=0 the memory is assumed to answer every cycle.
    assign mem_done = (WAIT_MEM != 0) ? mem_ready : 1'b1;

    assign state = state_q;

    // Decode the ALU operation for register and immediate arithmetic.
    always_comb begin
        funct_op = ALU_ADD;
        case (funct3)
            3'b000:  funct_op = (op[5] && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  funct_op = ALU_SLL;
            3'b010:  funct_op = ALU_SLT;
            3'b011:  funct_op = ALU_SLTU;
            3'b100:  funct_op = ALU_XOR;
            3'b101:  funct_op = funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  funct_op = ALU_OR;
            default: funct_op = ALU_AND;
        endcase
        funct_unsupported = NARROW_ALU &&
                            ((funct3 == 3'b001) || (funct3 == 3'b011) ||
                             (funct3 == 3'b100) || (funct3 == 3'b101));
    end

    // Next state and Moore outputs for the current state.
    always_comb begin
        // NOTE: every output and state_d gets a default before the case, so
        // no path through this block leaves a signal unassigned (no latches).
        state_d    = state_q;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_RD2;
        result_src = RES_ALUOUT;
        imm_src    = IMM_I;
        alu_code   = ALU_ADD;
        illegal    = 1'b0;

        case (state_q)
            S_FETCH: begin
                // PC+4 computed on the ALU while the instruction is read.
                adr_src    = 1'b0;
                alu_src_a  = SRC_A_PC;
                alu_src_b  = SRC_B_FOUR;
                alu_code   = ALU_ADD;
                result_src = RES_ALURES;
                if (mem_done) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end

            S_DECODE: begin
                // Speculative branch/jal target OldPC+imm into ALUOut.
                alu_src_a = SRC_A_OLDPC;
                alu_src_b = SRC_B_IMM;
                alu_code  = ALU_ADD;
                case (op)
                    OP_STORE:  imm_src = IMM_S;
                    OP_BRANCH: imm_src = IMM_B;
                    OP_JAL:    imm_src = IMM_J;
                    OP_LUI:    imm_src = IMM_U;
                    default:   imm_src = IMM_I;
                endcase
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    default:           state_d = S_TRAP;
                endcase
            end

            S_MEMADR: begin
                alu_src_a = SRC_A_RD1;
                alu_src_b = SRC_B_IMM;
                alu_code  = ALU_ADD;
                state_d   = op[5] ? S_MEMWRITE : S_MEMREAD;
            end

            S_MEMREAD: begin
                adr_src    = 1'b1;
                result_src = RES_ALUOUT;
                if (mem_done) begin
                    state_d = S_MEMWB;
                end
            end

            S_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end

            S_MEMWRITE: begin
                // Strobe and address held steady for the whole wait.
                adr_src    = 1'b1;
                result_src = RES_ALUOUT;
                mem_write  = 1'b1;
                if (mem_done) begin
                    state_d = S_FETCH;
                end
            end

            S_EXECR: begin
                alu_src_a = SRC_A_RD1;
                alu_src_b = SRC_B_RD2;
                alu_code  = funct_op;
                state_d   = funct_unsupported ? S_TRAP : S_ALUWB;
            end

            S_EXECI: begin
                alu_src_a = SRC_A_RD1;
                alu_src_b = SRC_B_IMM;
                alu_code  = funct_op;
                state_d   = funct_unsupported ? S_TRAP : S_ALUWB;
            end

            S_ALUWB: begin
                result_src = RES_ALUOUT;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end

            S_BRANCH: begin
                // beq takes on zero, bne (funct3[0]=1) on non-zero.
                alu_src_a  = SRC_A_RD1;
                alu_src_b  = SRC_B_RD2;
                alu_code   = ALU_SUB;
                result_src = RES_ALUOUT;
                pc_write   = zero ^ funct3[0];
                state_d    = S_FETCH;
            end

            S_JAL: begin
                // PC <- target held in ALUOut; ALU forms the link OldPC+4.
                alu_src_a  = SRC_A_OLDPC;
                alu_src_b  = SRC_B_FOUR;
                alu_code   = ALU_ADD;
                result_src = RES_ALUOUT;
                pc_write   = 1'b1;
                state_d    = S_ALUWB;
            end

            S_JALR: begin
                // Register-relative target into ALUOut, then share JAL.
                alu_src_a = SRC_A_RD1;
                alu_src_b = SRC_B_IMM;
                imm_src   = IMM_I;
                alu_code  = ALU_ADD;
                state_d   = S_JAL;
            end

            S_LUI: begin
                imm_src    = IMM_U;
                result_src = RES_IMMEXT;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end

            S_TRAP: begin
                illegal = 1'b1;
                state_d = S_TRAP;
            end

            default: begin
                // Unused encodings are treated as a trap.
                state_d = S_TRAP;
            end
        endcase

        // Reset aborts the instruction: no write may land in the reset cycle.
        if (reset) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
            mem_write = 1'b0;
        end
    end

    // Drive the ALU control at the configured width.
    assign alu_control = ALUCTRL_W'(alu_code);

    // State register with synchronous reset to FETCH.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller
// Directed and randomized checks of the multi-cycle controller. Expected
// behaviour comes from per-instruction step lists, latency/strobe totals and
// the funct3 decode table; three instances cover ALUCTRL_W=4/3 and WAIT_MEM=0.
module tb_multicycle_controller;

    localparam int ST_FETCH = 0, ST_DECODE = 1, ST_MEMADR = 2, ST_MEMREAD = 3,
                   ST_MEMWB = 4, ST_MEMWRITE = 5, ST_EXECR = 6, ST_EXECI = 7,
                   ST_ALUWB = 8, ST_BRANCH = 9, ST_JAL = 10, ST_JALR = 11,
                   ST_LUI = 12, ST_TRAP = 15;

    localparam int C_LW = 0, C_SW = 1, C_R = 2, C_I = 3, C_BR = 4,
                   C_JAL = 5, C_JALR = 6, C_LUI = 7, C_BAD = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;

    // main instance: ALUCTRL_W=4, WAIT_MEM=1
    logic       x_pcw, x_irw, x_rgw, x_mw, x_adr, x_ill;
    logic [1:0] x_sa, x_sb, x_res;
    logic [2:0] x_imm;
    logic [3:0] x_alu, x_state;
    // narrow ALU instance: ALUCTRL_W=3
    logic       t_pcw, t_irw, t_rgw, t_mw, t_adr, t_ill;
    logic [1:0] t_sa, t_sb, t_res;
    logic [2:0] t_imm, t_alu;
    logic [3:0] t_state;
    // no-wait instance: WAIT_MEM=0
    logic       w_pcw, w_irw, w_rgw, w_mw, w_adr, w_ill;
    logic [1:0] w_sa, w_sb, w_res;
    logic [2:0] w_imm;
    logic [3:0] w_alu, w_state;

    int n_cmp = 0;
    int n_err = 0;

    multicycle_controller #(.ALUCTRL_W(4), .WAIT_MEM(1)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready),
        .pc_write(x_pcw), .ir_write(x_irw), .reg_write(x_rgw), .mem_write(x_mw),
        .adr_src(x_adr), .alu_src_a(x_sa), .alu_src_b(x_sb), .result_src(x_res),
        .imm_src(x_imm), .alu_control(x_alu), .illegal(x_ill), .state(x_state)
    );

    multicycle_controller #(.ALUCTRL_W(3), .WAIT_MEM(1)) dut3 (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready),
        .pc_write(t_pcw), .ir_write(t_irw), .reg_write(t_rgw), .mem_write(t_mw),
        .adr_src(t_adr), .alu_src_a(t_sa), .alu_src_b(t_sb), .result_src(t_res),
        .imm_src(t_imm), .alu_control(t_alu), .illegal(t_ill), .state(t_state)
    );

    multicycle_controller #(.ALUCTRL_W(4), .WAIT_MEM(0)) dut0 (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready),
        .pc_write(w_pcw), .ir_write(w_irw), .reg_write(w_rgw), .mem_write(w_mw),
        .adr_src(w_adr), .alu_src_a(w_sa), .alu_src_b(w_sb), .result_src(w_res),
        .imm_src(w_imm), .alu_control(w_alu), .illegal(w_ill), .state(w_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] opcode_of(input int cls);
        case (cls)
            C_LW:    return 7'b0000011;
            C_SW:    return 7'b0100011;
            C_R:     return 7'b0110011;
            C_I:     return 7'b0010011;
            C_BR:    return 7'b1100011;
            C_JAL:   return 7'b1101111;
            C_JALR:  return 7'b1100111;
            C_LUI:   return 7'b0110111;
            default: return 7'b0000000;
        endcase
    endfunction

    // ALU operation number from the funct3 table (ADD=0 ... SLTU=9).
    function automatic int exp_alu(input logic op5, input logic [2:0] f3, input logic f7);
        case (f3)
            3'd0:    return (op5 && f7) ? 1 : 0;
            3'd1:    return 6;
            3'd2:    return 5;
            3'd3:    return 9;
            3'd4:    return 4;
            3'd5:    return f7 ? 8 : 7;
            3'd6:    return 3;
            default: return 2;
        endcase
    endfunction

    // Reset for two edges; strobes must stay low while reset is high.
    task automatic do_reset();
        reset = 1'b1;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_state", x_state, ST_FETCH);
        check("rst_illegal", x_ill, 0);
        check("rst_strobes", {x_pcw, x_irw, x_rgw, x_mw}, 0);
        check("rst_illegal_w3", t_ill, 0);
        check("rst_state_nowait", w_state, ST_FETCH);
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Run one instruction on the main instance from FETCH back to FETCH.
    // wf = mem_ready-low cycles in FETCH, wm = in MEMREAD/MEMWRITE.
    task automatic run_instr(input int cls, input logic [2:0] f3, input logic f7,
                             input logic z, input int wf, input int wm);
        int seq[$];
        int idx, es, wf_left, wm_left;
        int pcw, rgw, mwc, irw;
        int exp_pcw, exp_rgw, exp_res, exp_imm;
        logic mr;
        seq.delete();
        seq.push_back(ST_FETCH);
        seq.push_back(ST_DECODE);
        exp_res = 0;
        exp_imm = 0;
        case (cls)
            C_LW:   begin seq.push_back(ST_MEMADR); seq.push_back(ST_MEMREAD);
                          seq.push_back(ST_MEMWB); exp_res = 1; end
            C_SW:   begin seq.push_back(ST_MEMADR); seq.push_back(ST_MEMWRITE);
                          exp_imm = 1; end
            C_R:    begin seq.push_back(ST_EXECR); seq.push_back(ST_ALUWB); end
            C_I:    begin seq.push_back(ST_EXECI); seq.push_back(ST_ALUWB); end
            C_BR:   begin seq.push_back(ST_BRANCH); exp_imm = 2; end
            C_JAL:  begin seq.push_back(ST_JAL); seq.push_back(ST_ALUWB); exp_imm = 3; end
            C_JALR: begin seq.push_back(ST_JALR); seq.push_back(ST_JAL);
                          seq.push_back(ST_ALUWB); end
            C_LUI:  begin seq.push_back(ST_LUI); exp_res = 3; exp_imm = 4; end
            default: seq.push_back(ST_TRAP);
        endcase

        exp_pcw = 1;
        if (cls == C_BR) exp_pcw += (f3 == 3'd0) ? int'(z) : int'(!z);
        if (cls == C_JAL || cls == C_JALR) exp_pcw += 1;
        exp_rgw = (cls == C_LW || cls == C_R || cls == C_I || cls == C_JAL ||
                   cls == C_JALR || cls == C_LUI) ? 1 : 0;

        op = opcode_of(cls);
        funct3 = f3;
        funct7b5 = f7;
        zero = z;
        wf_left = wf;
        wm_left = wm;
        pcw = 0; rgw = 0; mwc = 0; irw = 0;
        idx = 0;
        while (idx < seq.size()) begin
            es = seq[idx];
            mr = 1'b1;
            if (es == ST_FETCH && wf_left > 0) mr = 1'b0;
            if ((es == ST_MEMREAD || es == ST_MEMWRITE) && wm_left > 0) mr = 1'b0;
            mem_ready = mr;
            @(negedge clk);
            check("state", x_state, es);
            pcw += int'(x_pcw);
            rgw += int'(x_rgw);
            mwc += int'(x_mw);
            irw += int'(x_irw);
            if (es == ST_DECODE) check("decode_imm_src", x_imm, exp_imm);
            if (es == ST_EXECR || es == ST_EXECI)
                check("exec_alu", x_alu, exp_alu(op[5], f3, f7));
            if (es == ST_BRANCH) check("branch_alu_sub", x_alu, 1);
            if (x_rgw) check("wb_result_src", x_res, exp_res);
            @(posedge clk); #1;
            if (!mr) begin
                if (es == ST_FETCH) wf_left--;
                else wm_left--;
            end else begin
                idx++;
            end
        end
        check("pc_write_count", pcw, exp_pcw);
        check("reg_write_count", rgw, exp_rgw);
        check("mem_write_cycles", mwc, (cls == C_SW) ? 1 + wm : 0);
        check("ir_write_count", irw, 1);
        check("illegal_after", x_ill, (cls == C_BAD) ? 1 : 0);
    endtask

    initial begin
        int exp3 [5];
        int expw [6];
        int cls, wf, wm;
        logic [2:0] f3;
        logic f7, z;

        do_reset();

        // add, sub, srai on the wide ALU
        run_instr(C_R, 3'd0, 1'b0, 1'b0, 0, 0);
        run_instr(C_R, 3'd0, 1'b1, 1'b0, 0, 0);
        run_instr(C_I, 3'd5, 1'b1, 1'b0, 0, 0);
        // beq and bne with zero=1
        run_instr(C_BR, 3'd0, 1'b0, 1'b1, 0, 0);
        run_instr(C_BR, 3'd1, 1'b0, 1'b1, 0, 0);
        // lw with two wait cycles, sw with three
        run_instr(C_LW, 3'd2, 1'b0, 1'b0, 0, 2);
        run_instr(C_SW, 3'd2, 1'b0, 1'b0, 0, 3);
        // jumps, lui, and fetch stalls
        run_instr(C_JALR, 3'd0, 1'b0, 1'b0, 0, 0);
        run_instr(C_JAL, 3'd0, 1'b0, 1'b0, 1, 0);
        run_instr(C_LUI, 3'd0, 1'b0, 1'b0, 2, 0);
        run_instr(C_I, 3'd0, 1'b1, 1'b0, 0, 0);

        // randomized legal instruction stream
        for (int n = 0; n < 80; n++) begin
            cls = int'($urandom_range(0, 7));
            f3 = 3'($urandom_range(0, 7));
            f7 = 1'($urandom_range(0, 1));
            z = 1'($urandom_range(0, 1));
            wf = int'($urandom_range(0, 2));
            wm = int'($urandom_range(0, 3));
            if (cls == C_BR) f3 = {2'b00, f3[0]};
            run_instr(cls, f3, f7, z, wf, wm);
        end

        // reset while a store waits on memory
        do_reset();
        op = 7'b0100011;
        funct3 = 3'd2;
        mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        mem_ready = 1'b0;
        @(negedge clk);
        check("sw_wait_state", x_state, ST_MEMWRITE);
        check("sw_wait_mem_write", x_mw, 1);
        check("sw_wait_adr_src", x_adr, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("abort_strobes", {x_pcw, x_irw, x_rgw, x_mw}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_next_state", x_state, ST_FETCH);
        @(posedge clk); #1;

        // srai on the 3-bit ALU traps
        do_reset();
        exp3 = '{ST_FETCH, ST_DECODE, ST_EXECI, ST_TRAP, ST_TRAP};
        op = 7'b0010011;
        funct3 = 3'd5;
        funct7b5 = 1'b1;
        mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("w3_srai_state", t_state, exp3[i]);
            @(posedge clk); #1;
        end
        check("w3_illegal", t_ill, 1);

        // WAIT_MEM=0: lw with memory never ready still takes 5 cycles
        do_reset();
        expw = '{ST_FETCH, ST_DECODE, ST_MEMADR, ST_MEMREAD, ST_MEMWB, ST_FETCH};
        op = 7'b0000011;
        funct3 = 3'd2;
        mem_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("nowait_state", w_state, expw[i]);
            if (i == 0) check("nowait_ir_write", w_irw, 1);
            if (i == 4) check("nowait_reg_write", w_rgw, 1);
            @(posedge clk); #1;
        end

        // illegal opcode on the main instance is sticky until reset
        do_reset();
        run_instr(C_BAD, 3'd0, 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            mem_ready = 1'b1;
            @(negedge clk);
            check("trap_hold_state", x_state, ST_TRAP);
            check("trap_hold_illegal", x_ill, 1);
            check("trap_hold_strobes", {x_pcw, x_irw, x_rgw, x_mw}, 0);
            @(posedge clk); #1;
        end
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
